dct_coef_mac: RTL and testbench

//  Computes one 2-D DCT coefficient for one 8x8 pixel block.
//  - Accepts 64 pixels in row-major order over a valid/ready stream.
//  - Drives the row/column index (n1, n2) to a dct_cos_lut instance, such as
//    k1_4_k2_0_lut, and multiplies each level-shifted pixel by the returned
//    cos_term, then accumulates the products.
//  - Emits the scaled coefficient on a valid/ready output.
//  - One instance sits directly downstream of each (k1,k2) cos LUT.

---
 rtl/dct_coef_mac.sv | 148 ++++++++++++++
 tb/tb_dct_coef_mac.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_coef_mac.sv
// ---------------------------------------------------------------------------
// dct_coef_mac
//
// Computes one 2-D DCT coefficient for one 8x8 pixel block. Pixels arrive in
// row-major order on a valid/ready stream. The block drives the row/column
// index of the next expected pixel to an external cos LUT. It multiplies each
// level-shifted pixel by the returned cos term and accumulates the products.
// The scaled, saturated coefficient is then presented on a valid/ready output.
//
// Handshake rule (both streams): a beat transfers on a rising clock edge
// where valid && ready are both high. A producer holds valid and data stable
// until the beat transfers. A consumer may raise or drop ready freely.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous, active-high reset
//   i_pix_valid    pixel stream valid
//   i_pix_data     unsigned pixel; pixel i sits at row i/8, column i%8
//   o_pix_ready    block accepts a pixel this cycle
//   o_n1, o_n2     row/column of the next expected pixel (to the cos LUT)
//   i_cos_term     signed fixed-point LUT result for the current o_n1/o_n2
//   o_coef_valid   coefficient valid
//   o_coef_data    signed 32-bit coefficient
//   i_coef_ready   downstream accepts the coefficient
//   o_busy         a block is in progress (count != 0, or DRAIN/OUT)
//   o_state        FSM state for debug and checkers (0 ACCUM, 1 DRAIN, 2 OUT)
// ---------------------------------------------------------------------------
module dct_coef_mac #(
    parameter int PIX_W       = 8,
    parameter int COS_W       = 32,
    parameter int ACC_W       = 48,
    parameter int FRAC_BITS   = 8,
    parameter int LEVEL_SHIFT = 128
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_pix_valid,
    input  logic [PIX_W-1:0]        i_pix_data,
    output logic                    o_pix_ready,
    output logic [2:0]              o_n1,
    output logic [2:0]              o_n2,
    input  logic signed [COS_W-1:0] i_cos_term,
    output logic                    o_coef_valid,
    output logic [31:0]             o_coef_data,
    input  logic                    i_coef_ready,
    output logic                    o_busy,
    output logic [1:0]              o_state
);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    localparam int MUL_W = PIX_W + 1 + COS_W;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [5:0]               r_count;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_prod;
    logic                     r_prod_vld;
    logic                     r_first;
    logic [31:0]              r_coef;

    logic                     w_accept;
    logic signed [PIX_W:0]    w_sample;
    logic signed [MUL_W-1:0]  w_mult;
    logic signed [ACC_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [31:0]              w_sat;
    logic                     w_fits;

    assign o_pix_ready = (r_state == ST_ACCUM) && !i_rst;
    assign w_accept    = i_pix_valid && o_pix_ready;

    // Index comes straight from the pixel counter, so it holds during bubbles.
    assign o_n1 = r_count[5:3];
    assign o_n2 = r_count[2:0];

    // Stage 1: level shift into a signed PIX_W+1 value, then full-width multiply.
    assign w_sample = $signed({1'b0, i_pix_data}) - $signed((PIX_W+1)'(LEVEL_SHIFT));
    assign w_mult   = w_sample * i_cos_term;
    assign w_prod   = {{(ACC_W-MUL_W){w_mult[MUL_W-1]}}, w_mult};

    // Stage 2: the first product of a block replaces the accumulator. Any
    // leftover from an earlier block therefore never needs an explicit clear.
    always_comb begin
        w_acc_next = r_acc;
        if (r_prod_vld) begin
            w_acc_next = r_first ? r_prod : (r_acc + r_prod);
        end
    end

    // The coefficient is captured on leaving DRAIN. At that edge the last
    // product is still being folded in, so scale the next accumulator value.
    assign w_shifted = w_acc_next >>> FRAC_BITS;
    assign w_fits    = (&w_shifted[ACC_W-1:31]) || !(|w_shifted[ACC_W-1:31]);

    always_comb begin
        w_sat = w_shifted[31:0];
        if (!w_fits) begin
            w_sat = w_shifted[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_accept && (r_count == 6'd63)) w_state_next = ST_DRAIN;
            ST_DRAIN: w_state_next = ST_OUT;
            ST_OUT:   if (i_coef_ready) w_state_next = ST_ACCUM;
            default:  w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_ACCUM;
            r_count    <= 6'd0;
            r_acc      <= '0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_first    <= 1'b0;
            r_coef     <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_prod_vld <= w_accept;
            r_acc      <= w_acc_next;
            if (w_accept) begin
                r_count <= r_count + 6'd1;  // wraps 63 -> 0 at end of block
                r_prod  <= w_prod;
                r_first <= (r_count == 6'd0);
            end
            if (r_state == ST_DRAIN) begin
                r_coef <= w_sat;
            end
        end
    end

    assign o_coef_valid = (r_state == ST_OUT);
    assign o_coef_data  = r_coef;
    assign o_busy       = (r_count != 6'd0) || (r_state == ST_DRAIN) || (r_state == ST_OUT);
    assign o_state      = r_state;

endmodule

// File: tb/tb_dct_coef_mac.sv
// ---------------------------------------------------------------------------
// tb_dct_coef_mac
//
// Bench for dct_coef_mac. A behavioural cos LUT drives i_cos_term from
// o_n1/o_n2. It has three modes:
//   0  k1=4,k2=0 table
//   1  constant 0x7FFFFFFF
//   2  per-index table filled by the bench
// The reference coefficient is the plain sum over the block of
// (pixel - 128) * lut(i), floored by 2^8 and saturated to 32 bits.
// ---------------------------------------------------------------------------
module tb_dct_coef_mac;

    logic               clk = 1'b0;
    logic               rst;
    logic               pix_valid;
    logic [7:0]         pix_data;
    logic               pix_ready;
    logic [2:0]         n1;
    logic [2:0]         n2;
    logic signed [31:0] cos_term;
    logic               coef_valid;
    logic [31:0]        coef_data;
    logic               coef_ready;
    logic               busy;
    logic [1:0]         state_dbg;

    int          errors = 0;
    int          checks = 0;
    int          lut_mode = 0;
    int          rand_tab[64];
    logic [7:0]  blk[64];
    logic [31:0] exp_q[$];

    dct_coef_mac dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pix_valid  (pix_valid),
        .i_pix_data   (pix_data),
        .o_pix_ready  (pix_ready),
        .o_n1         (n1),
        .o_n2         (n2),
        .i_cos_term   (cos_term),
        .o_coef_valid (coef_valid),
        .o_coef_data  (coef_data),
        .i_coef_ready (coef_ready),
        .o_busy       (busy),
        .o_state      (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- cos LUT model ----------------
    always_comb begin
        if (lut_mode == 1)
            cos_term = 32'sh7FFF_FFFF;
        else if (lut_mode == 2)
            cos_term = rand_tab[{n1, n2}];
        else
            cos_term = (n1 == 3'd0 || n1 == 3'd3 || n1 == 3'd4 || n1 == 3'd7) ? 32'sd180 : -32'sd180;
    end

    // ---------------- reference model ----------------
    function automatic longint ref_lut(input int idx);
        int row;
        row = idx / 8;
        if (lut_mode == 1) return 64'sd2147483647;
        if (lut_mode == 2) return longint'(rand_tab[idx]);
        return (row == 0 || row == 3 || row == 4 || row == 7) ? 64'sd180 : -64'sd180;
    endfunction

    function automatic logic [31:0] ref_coef();
        longint acc;
        longint sh;
        acc = 0;
        for (int i = 0; i < 64; i++)
            acc += (longint'(blk[i]) - 128) * ref_lut(i);
        sh = acc >>> 8;
        if (sh > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (sh < -64'sd2147483648) return 32'h8000_0000;
        return sh[31:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends pixels blk[0 .. max_pix-1], dropping valid on about bubble_pct % of cycles.
    task automatic send_block(input int bubble_pct, input int max_pix);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < max_pix && cyc < 3000) begin
            checks++;
            if ({n1, n2} !== 6'(i) || busy !== (i != 0)) begin
                errors++;
                $display("FAIL index_busy: pixel %0d n1:n2=%0d:%0d busy=%b, required %0d:%0d busy=%b",
                         i, n1, n2, busy, i / 8, i % 8, (i != 0));
            end
            pix_valid = ($urandom_range(0, 99) >= bubble_pct);
            pix_data  = blk[i];
            if (pix_valid && pix_ready) i++;
            step();
            cyc++;
        end
        pix_valid = 1'b0;
        if (i < max_pix) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: accepted %0d of %0d pixels", i, max_pix);
        end
    endtask

    // Called one cycle after the last pixel: expects DRAIN, then OUT next cycle.
    task automatic check_latency();
        checks++;
        if (coef_valid !== 1'b0 || pix_ready !== 1'b0 || busy !== 1'b1 || {n1, n2} !== 6'd0) begin
            errors++;
            $display("FAIL drain_cycle: coef_valid=%b pix_ready=%b busy=%b n1:n2=%0d:%0d, required 0 0 1 0:0",
                     coef_valid, pix_ready, busy, n1, n2);
        end
        step();
        checks++;
        if (coef_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: coef_valid=%b at t+2, required 1", coef_valid);
        end
    endtask

    // Waits for a coefficient and holds ready low for `hold` cycles.
    // Then it takes the coefficient and checks it against the scoreboard.
    task automatic recv_coef(input int hold);
        int          cyc;
        logic [31:0] held;
        logic [31:0] exp;
        cyc = 0;
        while (coef_valid !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        checks++;
        if (coef_valid !== 1'b1) begin
            errors++;
            $display("FAIL coef_timeout: coef_valid=%b after %0d cycles, required 1", coef_valid, cyc);
            return;
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (coef_data !== exp || busy !== 1'b1) begin
            errors++;
            $display("FAIL coef_data: got 0x%08h busy=%b, required 0x%08h busy=1", coef_data, busy, exp);
        end
        held = coef_data;
        for (int k = 0; k < hold; k++) begin
            step();
            checks++;
            if (coef_valid !== 1'b1 || coef_data !== held || pix_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d valid=%b data=0x%08h pix_ready=%b, required 1 0x%08h 0",
                         k, coef_valid, coef_data, pix_ready, held);
            end
        end
        coef_ready = 1'b1;
        step();
        coef_ready = 1'b0;
        checks++;
        if (coef_valid !== 1'b0 || pix_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_handshake: valid=%b pix_ready=%b busy=%b, required 0 1 0",
                     coef_valid, pix_ready, busy);
        end
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < 64; i++) blk[i] = v;
    endtask

    task automatic fill_rows();
        for (int i = 0; i < 64; i++)
            blk[i] = (i / 8 == 0 || i / 8 == 3 || i / 8 == 4 || i / 8 == 7) ? 8'd255 : 8'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (pix_ready !== 1'b0 || coef_valid !== 1'b0 || busy !== 1'b0 ||
            coef_data !== 32'd0 || {n1, n2} !== 6'd0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL %s: pix_ready=%b coef_valid=%b busy=%b coef_data=0x%08h n1:n2=%0d:%0d state=%0d, required all 0",
                     tag, pix_ready, coef_valid, busy, coef_data, n1, n2, state_dbg);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_data = 8'd0;
        coef_ready = 1'b0;
        #2;
        check_reset_outputs("reset_state");
        repeat (3) step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_flat_block();
        lut_mode = 0;
        fill_const(8'd128);
        exp_q.push_back(32'd0);
        send_block(0, 64);
        check_latency();
        recv_coef(0);
    endtask

    task automatic test_rows();
        lut_mode = 0;
        fill_rows();
        exp_q.push_back(32'd5737);
        send_block(0, 64);
        check_latency();
        recv_coef(0);
    endtask

    task automatic test_bubbles();
        lut_mode = 0;
        fill_rows();
        exp_q.push_back(32'd5737);
        send_block(40, 64);
        check_latency();
        recv_coef(0);
    endtask

    task automatic test_backpressure();
        lut_mode = 0;
        fill_rows();
        exp_q.push_back(32'd5737);
        send_block(0, 64);
        check_latency();
        recv_coef(10);
        fill_const(8'd128);
        exp_q.push_back(32'd0);
        send_block(0, 64);
        check_latency();
        recv_coef(0);
    endtask

    task automatic test_reset_mid_block();
        lut_mode = 0;
        fill_rows();
        send_block(0, 30);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) step();
        rst = 1'b0;
        step();
        checks++;
        if (coef_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: coef_valid=%b busy=%b after reset, required 0 0", coef_valid, busy);
        end
        exp_q.push_back(32'd5737);
        send_block(0, 64);
        check_latency();
        recv_coef(0);
    endtask

    task automatic test_saturation();
        lut_mode = 1;
        fill_const(8'd255);
        exp_q.push_back(32'h7FFF_FFFF);
        send_block(0, 64);
        check_latency();
        recv_coef(0);
        lut_mode = 2;
        for (int i = 0; i < 64; i++) rand_tab[i] = 32'sh8000_0000;
        exp_q.push_back(32'h8000_0000);
        send_block(0, 64);
        check_latency();
        recv_coef(0);
    endtask

    task automatic test_random();
        lut_mode = 2;
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 64; i++) begin
                blk[i]      = 8'($urandom_range(0, 255));
                rand_tab[i] = int'($urandom_range(0, 8000)) - 4000;
            end
            exp_q.push_back(ref_coef());
            send_block(30, 64);
            check_latency();
            recv_coef(int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_back_to_back();
        lut_mode = 0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 64; i++) blk[i] = 8'($urandom_range(0, 255));
            exp_q.push_back(ref_coef());
            send_block(0, 64);
            check_latency();
            recv_coef(0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d expected coefficients never seen, required 0", exp_q.size());
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_flat_block();
        test_rows();
        test_bubbles();
        test_backpressure();
        test_reset_mid_block();
        test_saturation();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
